// File: rtl/cache_wb_engine.sv
// ---------------------------------------------------------------------------
// cache_wb_engine
//
// Write-back engine that sits behind the cache write-hit controller. Dirty
// line notifications are buffered in a small coalescing FIFO, drained one at a
// time to main memory over a req/ack handshake, and reported back as cleaned
// so the cache can clear the line's dirty bit.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   dirty_valid/addr/data    dirty-line notification in
//   dirty_ready              notification accepted when high with dirty_valid
//   mem_req/addr/wdata       memory write request, held stable until mem_ack
//   mem_ack                  memory accepted the write (ignored when idle)
//   clean_valid/clean_addr   one-cycle pulse naming the line just written back
//   pending                  queued entries, including the one in flight
// ---------------------------------------------------------------------------
module cache_wb_engine #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dirty_valid,
    input  logic [ADDR_W-1:0]          dirty_addr,
    input  logic [DATA_W-1:0]          dirty_data,
    output logic                       dirty_ready,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_ack,
    output logic                       clean_valid,
    output logic [ADDR_W-1:0]          clean_addr,
    output logic [$clog2(DEPTH+1)-1:0] pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_e;

    // Queue storage
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    // FSM and registered outputs
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              clean_valid_q, clean_valid_d;
    logic [ADDR_W-1:0] clean_addr_q, clean_addr_d;

    logic              match;
    logic [PTR_W-1:0]  match_idx;
    logic              accept, do_push, do_coal, do_pop;

    // Coalesce lookup. The head is excluded: it is either in flight or about
    // to be latched into the request registers, so its data must not move.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        match     = 1'b0;
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (PTR_W'(i) != head_q) && (addr_q[i] == dirty_addr)) begin
                match     = 1'b1;
                match_idx = PTR_W'(i);
            end
        end
    end

    // A full queue refuses new addresses even if a pop lands this same cycle.
    assign dirty_ready = (count_q < CNT_W'(DEPTH)) | match;
    assign accept      = dirty_valid & dirty_ready;
    assign do_coal     = accept & match;
    assign do_push     = accept & ~match;
    assign do_pop      = (state_q == S_REQ) & mem_ack;

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        clean_valid_d = 1'b0;
        clean_addr_d  = clean_addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d     = S_REQ;
                    mem_addr_d  = addr_q[head_q];
                    mem_wdata_d = data_q[head_q];
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_d       = S_IDLE;
                    clean_valid_d = 1'b1;
                    clean_addr_d  = mem_addr_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q       <= S_IDLE;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            clean_valid_q <= 1'b0;
            clean_addr_q  <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            valid_q       <= '0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            clean_valid_q <= clean_valid_d;
            clean_addr_q  <= clean_addr_d;
            if (do_pop) begin
                head_q          <= head_q + PTR_W'(1);
                valid_q[head_q] <= 1'b0;
            end
            // Push and pop never share a slot: a pop needs count >= 1 and a
            // push into the head slot would need count == 0 or DEPTH.
            if (do_push) begin
                tail_q          <= tail_q + PTR_W'(1);
                valid_q[tail_q] <= 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: payload storage is not reset; valid bits and count gate every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[tail_q] <= dirty_addr;
            data_q[tail_q] <= dirty_data;
        end
        if (do_coal) begin
            data_q[match_idx] <= dirty_data;
        end
    end

    assign mem_req     = (state_q == S_REQ);
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign clean_valid = clean_valid_q;
    assign clean_addr  = clean_addr_q;
    assign pending     = count_q;

endmodule

// File: doc/cache_wb_engine.md
# cache_wb_engine

Write-back engine downstream of the cache write-hit controller. It accepts dirty-line notifications (address plus modified data) and buffers them in a small coalescing queue. It drains each line to main memory over a req/ack handshake, then reports the line as cleaned so the cache can clear its dirty bit. It closes the last step of the write-hit sequence: mark dirty, invalidate remote copies, eventually clean.

## Interface
- ADDR_W, 10, cache line address width (1024 lines)
- DATA_W, 16, line data width
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- dirty_valid  in  1  dirty-line notification valid
- dirty_addr  in  ADDR_W  address of the line just marked dirty
- dirty_data  in  DATA_W  modified line data
- dirty_ready  out  1  notification accepted this cycle when high with dirty_valid
- mem_req  out  1  memory write request, held until acknowledged
- mem_addr  out  ADDR_W  write address, stable while mem_req=1
- mem_wdata  out  DATA_W  write data, stable while mem_req=1
- mem_ack  in  1  memory accepted the write; sampled only while mem_req=1
- clean_valid  out  1  one-cycle pulse: the line at clean_addr is written back
- clean_addr  out  ADDR_W  address of the cleaned line
- pending  out  $clog2(DEPTH+1)  number of queued entries, including the one in flight

## Operation
- Queue: circular FIFO with DEPTH entries {addr, data, valid}. Head pointer, tail pointer, count register. Pointers wrap modulo DEPTH.
- Accept: a notification is taken when dirty_valid & dirty_ready at the clock edge.
- Coalescing: if dirty_addr matches a valid non-head entry, that entry's data is overwritten in place. Count and tail do not change.
  - The head entry is never a coalesce target. A write to the head address is appended as a new entry.
  - At most one entry can match, because the queue holds unique non-head addresses.
- Otherwise the notification is appended at the tail and count increments.
- dirty_ready = (count < DEPTH) | coalesce_match. It is combinational from the registered count and the incoming address.
  - When full, a new address is refused even if a pop happens in the same cycle.
- FSM has two states, IDLE and REQ.
  - IDLE → REQ when count ≠ 0. On that transition, mem_addr and mem_wdata are latched from the head and mem_req goes to 1.
  - REQ → IDLE when mem_ack=1. Next cycle: mem_req=0, head pops, count decrements, clean_valid=1, clean_addr = popped address.
  - REQ with mem_ack=0: hold. mem_req, mem_addr and mem_wdata are unchanged.
- mem_ack while mem_req=0 is ignored.
- Simultaneous append and pop in the same cycle: count is unchanged and both pointers advance.
- pending equals count.

## Timing
- Reset values (one cycle after rst=1 is sampled): mem_req=0, mem_addr=0, mem_wdata=0, clean_valid=0, clean_addr=0, pending=0, dirty_ready=1, state IDLE, pointers 0, all entries invalid.
- Reset mid-transaction: mem_req drops next cycle, the queue is discarded, and no clean_valid is issued for dropped entries.
- Accept at cycle N into an empty idle queue: pending=1 at N+1, mem_req=1 at N+2.
- mem_ack sampled at cycle M: mem_req=0 and clean_valid=1 at M+1. The next mem_req is no earlier than M+2.
- Minimum spacing between request starts is 2 cycles plus memory latency.
- clean_valid is exactly one cycle per acknowledged write.
- Cleans are reported in acceptance order of the first, non-coalesced notification.

## Test plan
- Single line: rst, then dirty addr=0x005 data=0xBEEF at cycle 2. Expect mem_req at cycle 4 with mem_addr=0x005, mem_wdata=0xBEEF. mem_ack at cycle 6 → clean_valid pulse at cycle 7 with clean_addr=0x005, pending 1→0.
- Coalesce: with a request to 0x001 in flight and mem_ack held low, push 0x002/0x1111 then 0x002/0x2222. Expect pending=2. After ack, the second request carries 0x002/0x2222, and only one clean is reported for 0x002.
- Head exclusion: while 0x003 is in flight, push 0x003/0xAAAA. Expect pending=2 and two memory writes to 0x003: the first with the old data, the second with 0xAAAA.
- Full: mem_ack held low, push 4 distinct addresses. Expect dirty_ready=0 for a fifth new address, dirty_ready=1 for the address of a queued non-head entry. After one ack, dirty_ready returns to 1.
- Back-to-back drain: 4 entries queued, mem_ack tied high. Expect 4 writes in FIFO order, mem_req asserted every other cycle, 4 clean pulses, pending reaching 0.
- Reset mid-request: rst asserted while mem_req=1 and pending=3. Expect mem_req=0, pending=0, and no clean_valid on the next cycle.
